// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, LSB first, start/busy/done handshake.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b via inverted b and carry-in of 1).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             sub_sel;
  logic [WIDTH-1:0] b_load;
  logic             cy_load;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Subtraction is a + ~b + 1; cin is ignored in that mode.
  assign b_load  = sub_sel ? ~b : b;
  assign cy_load = sub_sel ? 1'b1 : cin;

  assign fa_sum   = a_sh[0] ^ b_sh[0] ^ cy;
  assign fa_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & cy) | (b_sh[0] & cy);

  // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    res_next = res >> 1;
    res_next[WIDTH-1] = fa_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            cy    <= cy_load;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cy   <= fa_carry;
          res  <= res_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= fa_carry;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random adds against
// an arithmetic model; a second WIDTH=1 instance covers the single-bit boundary.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  logic start1, a1, b1, cin1, sub1;
  logic busy1, done1, sum1, cout1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sb);
    if (sb) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sb);
    int n, bc;
    logic [W:0] exp;
    exp = model(x, y, ci, sb);
    a = x; b = y; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = ~sb;
    n = 0; bc = busy ? 1 : 0;
    while (!done && n < 4 * W) begin
      @(posedge clk); #1;
      n++;
      if (busy) bc++;
    end
    check({tag, " latency"}, n, W);
    check({tag, " sum"}, sum, exp[W-1:0]);
    check({tag, " cout"}, cout, exp[W]);
    check({tag, " busy_cycles"}, bc, W + 1);
    @(posedge clk); #1;
    check({tag, " idle"}, {busy, done}, 2'b00);
    check({tag, " sum_held"}, sum, exp[W-1:0]);
  endtask

  initial begin
    int n, pulses, last_done, cyc;
    logic [W:0] exp;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0;
    #12;
    check("reset outputs", {busy, done, sum, cout}, '0);
    check("reset outputs w1", {busy1, done1, sum1, cout1}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add 3c+5a", 8'h3C, 8'h5A, 1'b0, 1'b0);
    do_op("add ff+01", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("add 00+00+1", 8'h00, 8'h00, 1'b1, 1'b0);
    do_op("add ff+ff+1", 8'hFF, 8'hFF, 1'b1, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    do_op("sub 05-07", 8'h05, 8'h07, 1'b1, 1'b1);
    do_op("sub 07-05", 8'h07, 8'h05, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 20; i++) begin
      logic sb;
`ifdef SERIAL_ADD_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      do_op("random", W'($urandom), W'($urandom), 1'($urandom), sb);
    end

    // start pulses at cycles 3 and 8 of a running add must be ignored
    exp = model(8'h3C, 8'h5A, 1'b0, 1'b0);
    a = 8'h3C; b = 8'h5A; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      start = (c == 3 || c == 8);
      a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      if (done) pulses++;
    end
    start = 1'b0;
    check("ignored start pulses", pulses, 1);
    check("ignored start sum", sum, exp[W-1:0]);
    check("ignored start cout", cout, exp[W]);
    check("ignored start idle", busy, 1'b0);

    // reset in the middle of RUN aborts immediately
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mid-run reset", {busy, done, sum, cout}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("after reset idle", {busy, done}, 2'b00);
    do_op("post-reset 10+20", 8'h10, 8'h20, 1'b0, 1'b0);

    // start held high: back-to-back results every W+2 cycles
    exp = model(8'h3C, 8'h5A, 1'b0, 1'b0);
    a = 8'h3C; b = 8'h5A; cin = 1'b0; sub = 1'b0; start = 1'b1;
    pulses = 0; last_done = -1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        if (last_done >= 0) check("b2b period", cyc - last_done, W + 2);
        last_done = cyc;
        pulses++;
      end
      if (pulses > 0) check("b2b sum stable", {cout, sum}, exp);
    end
    start = 1'b0;
    check("b2b pulse count", pulses >= 3, 1'b1);
    n = 0;
    while (busy && n < 4 * W) begin @(posedge clk); #1; n++; end
    check("b2b drain", busy, 1'b0);

    // WIDTH=1 instance: 1+1+1 and a few random single-bit adds
    for (int i = 0; i < 5; i++) begin
      logic x, y, ci;
      logic [1:0] e1;
      if (i == 0) begin x = 1'b1; y = 1'b1; ci = 1'b1; end
      else begin x = 1'($urandom); y = 1'($urandom); ci = 1'($urandom); end
      e1 = 2'(x) + 2'(y) + 2'(ci);
      a1 = x; b1 = y; cin1 = ci; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~x; b1 = ~y;
      n = 0;
      while (!done1 && n < 8) begin @(posedge clk); #1; n++; end
      check("w1 latency", n, 1);
      check("w1 result", {cout1, sum1}, e1);
      @(posedge clk); #1;
      check("w1 idle", {busy1, done1}, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
